// File: rtl/ahb_mem_responder.sv
// AHB-Lite responder: word-addressed 16-bit memory with configurable wait states
// and a two-cycle ERROR response for out-of-range or non-halfword accesses.
module ahb_mem_responder #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  RESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [2:0]            HBURST,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic                  HRESP
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    state_e                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic [2:0]            wait_cnt_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  legal;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx;
    logic                  mem_we;
    logic                  fwd;
    logic [DATA_WIDTH-1:0] rd_now;
    logic                  unused_bits;

    // HTRANS[1] set means NONSEQ or SEQ; IDLE and BUSY never start a transfer.
    assign accept = HSEL && HREADY && HTRANS[1];
    assign offset = HADDR - ADDR_WIDTH'(BASE_ADDR);
    assign idx    = offset[IDX_W-1:0];
    assign legal  = (HSIZE == 3'b001) &&
                    (32'(HADDR) >= BASE_ADDR) &&
                    (32'(HADDR) <= BASE_ADDR + MEM_DEPTH - 1);

    // The write of the beat in DATA lands on the same edge a pipelined read may be
    // accepted; forward HWDATA so a zero-wait read-after-write sees the new value.
    assign mem_we = (state_q == StData) && write_q;
    assign fwd    = mem_we && (idx_q == idx);
    assign rd_now = fwd ? HWDATA : mem[idx];

    assign unused_bits = ^{HBURST, HMASTLOCK, HTRANS[0], offset};

    // Memory array write port, no reset so contents survive RESET.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            mem[idx_q] <= HWDATA;
        end
    end

    // Response FSM with registered HREADY/HRESP/HRDATA.
    always_ff @(posedge HCLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            write_q    <= 1'b0;
            wait_cnt_q <= 3'd0;
            HREADY     <= 1'b1;
            HRESP      <= 1'b0;
            HRDATA     <= '0;
        end else begin
            case (state_q)
                StWait: begin
                    if (wait_cnt_q == 3'd0) begin
                        state_q <= StData;
                        HREADY  <= 1'b1;
                        HRESP   <= 1'b0;
                        HRDATA  <= write_q ? '0 : mem[idx_q];
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                StErr1: begin
                    state_q <= StErr2;
                    HREADY  <= 1'b1;
                    HRESP   <= 1'b1;
                    HRDATA  <= '0;
                end
                // StIdle, StData and StErr2 all present HREADY=1 and may take a new
                // address phase.
                default: begin
                    if (accept) begin
                        idx_q   <= idx;
                        write_q <= HWRITE;
                        if (!legal) begin
                            state_q <= StErr1;
                            HREADY  <= 1'b0;
                            HRESP   <= 1'b1;
                            HRDATA  <= '0;
                        end else if (WAIT_STATES > 0) begin
                            state_q    <= StWait;
                            wait_cnt_q <= 3'(WAIT_STATES - 1);
                            HREADY     <= 1'b0;
                            HRESP      <= 1'b0;
                            HRDATA     <= '0;
                        end else begin
                            state_q <= StData;
                            HREADY  <= 1'b1;
                            HRESP   <= 1'b0;
                            HRDATA  <= HWRITE ? '0 : rd_now;
                        end
                    end else begin
                        state_q <= StIdle;
                        HREADY  <= 1'b1;
                        HRESP   <= 1'b0;
                        HRDATA  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Self-checking bench: one zero-wait and one single-wait responder on shared bus wires,
// each selected by its own HSEL.
module tb_ahb_mem_responder;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        HCLK = 1'b0;
    logic        RESET;
    logic [1:0]  hsel;
    logic [15:0] haddr;
    logic [15:0] hwdata;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        hmastlock;
    logic [15:0] hrdata0, hrdata1;
    logic        hready0, hready1;
    logic        hresp0, hresp1;

    int checks = 0;
    int errors = 0;

    // Reference memories, one per responder, with a written-yet flag per word.
    logic [15:0] mdl   [2][256];
    bit          known [2][256];

    always #5 HCLK = ~HCLK;

    ahb_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .RESET(RESET), .HSEL(hsel[0]), .HADDR(haddr), .HWDATA(hwdata),
        .HBURST(hburst), .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite),
        .HMASTLOCK(hmastlock), .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
    );

    ahb_mem_responder #(.WAIT_STATES(1)) u_ws1 (
        .HCLK(HCLK), .RESET(RESET), .HSEL(hsel[1]), .HADDR(haddr), .HWDATA(hwdata),
        .HBURST(hburst), .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite),
        .HMASTLOCK(hmastlock), .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1)
    );

    function automatic logic get_rdy(input int s);
        return (s == 1) ? hready1 : hready0;
    endfunction

    function automatic logic get_resp(input int s);
        return (s == 1) ? hresp1 : hresp0;
    endfunction

    function automatic logic [15:0] get_rdata(input int s);
        return (s == 1) ? hrdata1 : hrdata0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compares {HREADY, HRESP, HRDATA} of one responder.
    task automatic chk_bus(input string name, input int s, input logic rdy, input logic resp,
                           input logic [15:0] rdata);
        logic [17:0] act;
        logic [17:0] exp;
        act = {get_rdy(s), get_resp(s), get_rdata(s)};
        exp = {rdy, resp, rdata};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual ready/resp/rdata=%b/%b/%h required=%b/%b/%h",
                     name, act[17], act[16], act[15:0], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // One non-pipelined transfer: address phase, then wait for HREADY in the data phase.
    task automatic do_xfer(input int s, input logic wr, input logic [15:0] addr,
                           input logic [2:0] size, input logic [15:0] wdata,
                           output int waits, output logic first_resp, output logic resp,
                           output logic [15:0] rdata);
        @(posedge HCLK); #1;
        hsel      = 2'b00;
        hsel[s]   = 1'b1;
        htrans    = T_NONSEQ;
        hburst    = 3'b000;
        haddr     = addr;
        hwrite    = wr;
        hsize     = size;
        @(posedge HCLK); #1;
        hsel       = 2'b00;
        htrans     = T_IDLE;
        hwdata     = wdata;
        waits      = 0;
        first_resp = get_resp(s);
        while (!get_rdy(s) && waits < 20) begin
            @(posedge HCLK); #1;
            waits++;
        end
        if (waits >= 20) begin
            errors++;
            $display("FAIL xfer_timeout: HREADY low for %0d cycles, required at most 20", waits);
        end
        resp  = get_resp(s);
        rdata = get_rdata(s);
    endtask

    // Address-phase slot of a pipelined sequence: >=0 beat offset, -1 BUSY, -2 end.
    task automatic drive_slot(input int s, input int v, input logic wr, input logic [15:0] base,
                              input logic first);
        hburst = 3'b001;
        hwrite = wr;
        hsize  = 3'b001;
        if (v >= 0) begin
            hsel[s] = 1'b1;
            htrans  = first ? T_NONSEQ : T_SEQ;
            haddr   = base + 16'(v);
        end else if (v == -1) begin
            hsel[s] = 1'b1;
            htrans  = T_BUSY;
        end else begin
            hsel   = 2'b00;
            htrans = T_IDLE;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [15:0] wdata;
        int          exp_waits;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [13];
        int          waits;
        logic        first_resp, resp;
        logic [15:0] rdata;
        logic [15:0] bvals [4];
        int          slots [10];

        vecs[0]  = '{1'b1, 16'h0010, 3'b001, 16'hBEEF, 1, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0010, 3'b001, 16'h0000, 1, 1'b0, 16'hBEEF};
        vecs[2]  = '{1'b1, 16'h0000, 3'b001, 16'h1234, 1, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 16'h0005, 3'b001, 16'h5678, 1, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 16'h0100, 3'b001, 16'hDEAD, 1, 1'b1, 16'h0000};
        vecs[5]  = '{1'b0, 16'h0005, 3'b010, 16'h0000, 1, 1'b1, 16'h0000};
        vecs[6]  = '{1'b0, 16'h0000, 3'b001, 16'h0000, 1, 1'b0, 16'h1234};
        vecs[7]  = '{1'b0, 16'h0005, 3'b001, 16'h0000, 1, 1'b0, 16'h5678};
        vecs[8]  = '{1'b1, 16'h00FF, 3'b001, 16'hCAFE, 1, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 16'h00FF, 3'b001, 16'h0000, 1, 1'b0, 16'hCAFE};
        vecs[10] = '{1'b0, 16'hFFFF, 3'b001, 16'h0000, 1, 1'b1, 16'h0000};
        vecs[11] = '{1'b1, 16'h0005, 3'b000, 16'h9999, 1, 1'b1, 16'h0000};
        vecs[12] = '{1'b0, 16'h0005, 3'b001, 16'h0000, 1, 1'b0, 16'h5678};

        bvals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        slots = '{0, 1, 2, -1, 3, 4, 5, 6, 7, -2};

        // Reset held two cycles, then IDLE traffic.
        RESET     = 1'b0;
        hsel      = 2'b00;
        haddr     = 16'h0;
        hwdata    = 16'h0;
        hburst    = 3'b000;
        hsize     = 3'b001;
        htrans    = T_IDLE;
        hwrite    = 1'b0;
        hmastlock = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        chk_bus("reset_ws0", 0, 1'b1, 1'b0, 16'h0000);
        chk_bus("reset_ws1", 1, 1'b1, 1'b0, 16'h0000);
        RESET = 1'b1;
        hsel  = 2'b11;
        haddr = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            @(posedge HCLK); #1;
            chk_bus($sformatf("idle_ws0_%0d", i), 0, 1'b1, 1'b0, 16'h0000);
            chk_bus($sformatf("idle_ws1_%0d", i), 1, 1'b1, 1'b0, 16'h0000);
        end
        hsel = 2'b00;

        // Table-driven single transfers on the one-wait responder.
        for (int i = 0; i < 13; i++) begin
            do_xfer(1, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                    waits, first_resp, resp, rdata);
            chk($sformatf("vec%0d_waits", i), waits, vecs[i].exp_waits);
            chk($sformatf("vec%0d_first_resp", i), 32'(first_resp), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_resp", i), 32'(resp), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
        end

        // Zero-wait INCR read burst of 4 beats.
        for (int i = 0; i < 4; i++) begin
            do_xfer(0, 1'b1, 16'h0020 + 16'(i), 3'b001, bvals[i], waits, first_resp, resp, rdata);
            chk($sformatf("preload%0d_waits", i), waits, 0);
        end
        @(posedge HCLK); #1;
        drive_slot(0, 0, 1'b0, 16'h0020, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge HCLK); #1;
            drive_slot(0, (i < 4) ? i : -2, 1'b0, 16'h0020, 1'b0);
            chk_bus($sformatf("burst_rd_%0d", i - 1), 0, 1'b1, 1'b0, bvals[i-1]);
        end

        // Zero-wait write immediately followed by a read of the same word.
        @(posedge HCLK); #1;
        hsel[0] = 1'b1; htrans = T_NONSEQ; haddr = 16'h0050; hwrite = 1'b1; hsize = 3'b001;
        @(posedge HCLK); #1;
        hwrite = 1'b0; hwdata = 16'h7777;
        chk_bus("raw_write_phase", 0, 1'b1, 1'b0, 16'h0000);
        @(posedge HCLK); #1;
        hsel = 2'b00; htrans = T_IDLE;
        chk_bus("raw_read_phase", 0, 1'b1, 1'b0, 16'h7777);

        // Zero-wait INCR write of 8 beats with a BUSY after the third beat.
        @(posedge HCLK); #1;
        drive_slot(0, slots[0], 1'b1, 16'h0040, 1'b1);
        for (int s = 1; s < 10; s++) begin
            @(posedge HCLK); #1;
            drive_slot(0, slots[s], 1'b1, 16'h0040, 1'b0);
            hwdata = (slots[s-1] >= 0) ? 16'(slots[s-1] + 1) : 16'h0000;
            chk_bus($sformatf("burst_wr_slot%0d", s - 1), 0, 1'b1, 1'b0, 16'h0000);
        end
        for (int i = 0; i < 8; i++) begin
            do_xfer(0, 1'b0, 16'h0040 + 16'(i), 3'b001, 16'h0, waits, first_resp, resp, rdata);
            chk($sformatf("wr_readback%0d", i), 32'(rdata), 32'(i + 1));
            chk($sformatf("wr_readback%0d_waits", i), waits, 0);
        end

        // Reset while a one-wait write sits in its WAIT cycle.
        do_xfer(1, 1'b1, 16'h0030, 3'b001, 16'h5555, waits, first_resp, resp, rdata);
        @(posedge HCLK); #1;
        hsel[1] = 1'b1; htrans = T_NONSEQ; haddr = 16'h0030; hwrite = 1'b1; hsize = 3'b001;
        @(posedge HCLK); #1;
        hsel = 2'b00; htrans = T_IDLE; hwdata = 16'hAAAA;
        chk_bus("rst_in_wait", 1, 1'b0, 1'b0, 16'h0000);
        RESET = 1'b0;
        #1;
        chk_bus("rst_async", 1, 1'b1, 1'b0, 16'h0000);
        @(posedge HCLK); #1;
        RESET = 1'b1;
        do_xfer(1, 1'b0, 16'h0030, 3'b001, 16'h0, waits, first_resp, resp, rdata);
        chk("rst_dropped_write", 32'(rdata), 32'h5555);

        // Random single transfers against the reference memories.
        for (int n = 0; n < 300; n++) begin
            int          s;
            logic        wr;
            logic [15:0] addr;
            logic [2:0]  size;
            logic [15:0] wdata;
            logic        ok;
            s     = int'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 263))
                                                : 16'($urandom_range(224, 254));
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
            wdata = 16'($urandom);
            ok    = (addr < 16'd256) && (size == 3'b001);
            do_xfer(s, wr, addr, size, wdata, waits, first_resp, resp, rdata);
            chk($sformatf("rnd%0d_waits", n), waits, ok ? s : 1);
            chk($sformatf("rnd%0d_first_resp", n), 32'(first_resp), 32'(!ok));
            chk($sformatf("rnd%0d_resp", n), 32'(resp), 32'(!ok));
            if (!ok || wr) begin
                chk($sformatf("rnd%0d_rdata", n), 32'(rdata), 32'h0);
            end else if (known[s][addr[7:0]]) begin
                chk($sformatf("rnd%0d_rdata", n), 32'(rdata), 32'(mdl[s][addr[7:0]]));
            end
            if (ok && wr) begin
                mdl[s][addr[7:0]]   = wdata;
                known[s][addr[7:0]] = 1'b1;
            end
        end

        @(posedge HCLK); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_mem_responder.md
Name: ahb_mem_responder

Overview:
- AHB-Lite style responder (slave end) for the CRC/SSP datapath: a single 16-bit-wide word-addressed memory that answers the AHB master's SINGLE and INCR transfers.
- Inserts a configurable number of wait states and returns a two-cycle ERROR response for illegal accesses.
- Supplies data words for master burst reads and stores the SUM results the master writes back.

Parameters:
- DATA_WIDTH, 16, HWDATA/HRDATA width and memory word width.
- ADDR_WIDTH, 16, HADDR width; addresses are halfword indices (consecutive words differ by 1).
- MEM_DEPTH, 256, number of memory words.
- BASE_ADDR, 0, first valid HADDR; valid range is BASE_ADDR .. BASE_ADDR+MEM_DEPTH-1.
- WAIT_STATES, 1, HREADY-low cycles inserted before every OKAY data phase (0..7).

Ports:
- HCLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- HSEL  input  1  slave select.
- HADDR  input  ADDR_WIDTH  transfer address (address phase).
- HWDATA  input  DATA_WIDTH  write data (data phase).
- HBURST  input  3  burst type; SINGLE=000 and INCR=001 are handled, other values are treated as INCR.
- HSIZE  input  3  transfer size; only HALFWORD=001 is legal.
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  input  1  1 = write, 0 = read.
- HMASTLOCK  input  1  ignored.
- HRDATA  output  DATA_WIDTH  read data; valid when HREADY=1 and HRESP=0 in a read data phase.
- HREADY  output  1  1 = data phase complete or bus free.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async, RESET=0): HREADY=1, HRESP=0, HRDATA=0, state IDLE, captured address/control cleared. Memory contents are not cleared.
- Address phase is accepted on a rising edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ.
  - Accepted phase latches HADDR, HWRITE, HSIZE.
  - IDLE/BUSY or HSEL=0 → no transfer; the responder stays or returns to IDLE with HREADY=1, HRESP=0.
- Legality check on the latched values: HSIZE==001 and BASE_ADDR <= HADDR <= BASE_ADDR+MEM_DEPTH-1. Memory index = HADDR-BASE_ADDR.
- States:
  - IDLE: HREADY=1, HRESP=0.
  - WAIT: HREADY=0, HRESP=0; counter counts WAIT_STATES cycles.
  - DATA: HREADY=1, HRESP=0; one cycle.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
- Transitions on an accepted legal transfer: WAIT if WAIT_STATES>0, else DATA directly. WAIT→DATA after WAIT_STATES cycles.
- Transitions on an accepted illegal transfer: ERR1→ERR2 unconditionally; error responses take no wait states.
- From DATA or ERR2: if a new address phase is accepted in that same cycle (pipelined, HREADY=1), go to WAIT/DATA/ERR1 for it; otherwise go to IDLE.
- Latency: an OKAY transfer completes exactly WAIT_STATES+1 cycles after address acceptance. Back-to-back INCR beats with WAIT_STATES=0 complete one per cycle.
- Write: mem[index] <= HWDATA on the rising edge that ends the DATA cycle.
- Read: HRDATA = mem[index] during DATA. A read following a write to the same address returns the newly written value.
- HRDATA = 0 in all states other than a read DATA cycle.
- Errors: memory is never modified, HRDATA=0. The master may drive IDLE during ERR2; its transfer is then not accepted.
- BUSY inside a burst: treated as no transfer, zero-wait OKAY; the next SEQ is accepted normally.
- HBURST is not checked for address continuity; every beat uses its own HADDR.
- Reset asserted mid-transfer: immediate return to IDLE outputs. A pending write is dropped and memory is unchanged for that beat.

Test Plan:
- Reset: RESET=0 for 2 cycles, then release → HREADY=1, HRESP=0, HRDATA=0; IDLE transfers on HTRANS=00 give no response change.
- Single write then single read, WAIT_STATES=1:
  - NONSEQ write HADDR=0x0010, HWDATA=0xBEEF → exactly 1 HREADY-low cycle, then OKAY.
  - NONSEQ read of 0x0010 → HRDATA=0xBEEF on its HREADY=1 cycle.
- INCR read burst of 4 beats from 0x0020, memory preloaded with 0x1111/0x2222/0x3333/0x4444, WAIT_STATES=0 → four consecutive HREADY=1 cycles returning those values in order, HRESP=0 throughout.
- INCR write of 8 beats to 0x0040 with SUM values 0x0001..0x0008, a BUSY inserted after beat 3 → readback of 0x0040..0x0047 gives 0x0001..0x0008; the BUSY cycle shows HREADY=1, HRESP=0.
- Out-of-range write to HADDR=0x0100 (MEM_DEPTH=256) and HSIZE=010 read at 0x0005 → each gets ERR1 (HREADY=0, HRESP=1) then ERR2 (HREADY=1, HRESP=1), memory at 0x0000/0x0005 unchanged, HRDATA=0.
- Reset during a WAIT cycle of a write of 0xAAAA to 0x0030 (old value 0x5555) → outputs return to reset values at once; subsequent read of 0x0030 returns 0x5555.
